// File: rtl/seg_scan_if.sv
// Bus bundle between the BCD decode stage / display pins and seg_scan_ctrl.
// Signals:
//   Seven0..3 : four active-low 7-segment patterns (bit0 = segment a)
//   DigEn     : per-digit enable, bit k enables digit k
//   Update    : request to load Seven0..3 at the next frame boundary
//   Bright    : brightness level (only meaningful with BRIGHT_EN)
//   SevOut    : segment drive, active-low
//   Dig       : digit anodes, active-low, one-hot-low when driving
//   UpdAck    : one-cycle pulse when the shadow load has happened
//   FrameDone : one-cycle pulse at the start of each frame
// master drives the requests; slave is the scan controller.
interface seg_scan_if;
    logic [6:0] Seven0;
    logic [6:0] Seven1;
    logic [6:0] Seven2;
    logic [6:0] Seven3;
    logic [3:0] DigEn;
    logic       Update;
    logic [2:0] Bright;
    logic [6:0] SevOut;
    logic [3:0] Dig;
    logic       UpdAck;
    logic       FrameDone;

    modport master (
        output Seven0, Seven1, Seven2, Seven3, DigEn, Update, Bright,
        input  SevOut, Dig, UpdAck, FrameDone
    );

    modport slave (
        input  Seven0, Seven1, Seven2, Seven3, DigEn, Update, Bright,
        output SevOut, Dig, UpdAck, FrameDone
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Refresh scheduler for a 4-digit multiplexed seven-segment display.
// Each digit owns a DIV-cycle slot: GAP blank cycles, then SHOW. Patterns
// are double-buffered and reloaded only at the frame-end edge.
// Ports:
//   CLK : system clock, rising edge
//   RST : asynchronous, active-high reset
//   bus : seg_scan_if.slave (patterns, DigEn, Update, Bright in;
//         SevOut, Dig, UpdAck, FrameDone out, all registered)
// Optional feature macro: BRIGHT_EN (PWM dimming inside SHOW using Bright).
module seg_scan_ctrl #(
    parameter int unsigned DIV = 50000,
    parameter int unsigned GAP = 500
) (
    input  logic        CLK,
    input  logic        RST,
    seg_scan_if.slave   bus
);
    localparam int unsigned CW = $clog2(DIV);

    typedef enum logic {BLANK, SHOW} state_t;

    state_t          state_q, state_nxt;
    logic [CW-1:0]   cnt_q, cnt_nxt;
    logic [1:0]      idx_q, idx_nxt;
    logic            first_q;
    logic [3:0]      en_q, en_nxt;
    logic            pend_q, pend_nxt;
    logic [6:0]      shadow_q [0:3];
    logic [6:0]      shadow_nxt [0:3];
    logic            wrap, frame_end, load, drive;
    logic [6:0]      sev_q, sev_nxt;
    logic [3:0]      dig_q, dig_nxt;
    logic            ack_q, fd_q;
`ifdef BRIGHT_EN
    logic [31:0]     ofs;
`else
    logic            unused_bright;
    assign unused_bright = ^bus.Bright;
`endif

    // State, counters, shadow buffer and registered outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= BLANK;
            cnt_q    <= '0;
            idx_q    <= '0;
            first_q  <= 1'b1;
            en_q     <= '0;
            pend_q   <= 1'b0;
            for (int k = 0; k < 4; k++) shadow_q[k] <= 7'h7F;
            sev_q    <= 7'h7F;
            dig_q    <= 4'hF;
            ack_q    <= 1'b0;
            fd_q     <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            cnt_q    <= cnt_nxt;
            idx_q    <= idx_nxt;
            first_q  <= 1'b0;
            en_q     <= en_nxt;
            pend_q   <= pend_nxt;
            for (int k = 0; k < 4; k++) shadow_q[k] <= shadow_nxt[k];
            sev_q    <= sev_nxt;
            dig_q    <= dig_nxt;
            ack_q    <= load;
            fd_q     <= frame_end;
        end
    end

    // Next-state and output decode; outputs are built from next values so
    // the registered pins line up with the counter in the same cycle.
    always_comb begin
        state_nxt = state_q;
        wrap      = (cnt_q == CW'(DIV - 1));
        cnt_nxt   = wrap ? '0 : cnt_q + CW'(1);
        idx_nxt   = wrap ? idx_q + 2'd1 : idx_q;
        frame_end = wrap && (idx_q == 2'd3);
        load      = frame_end && (pend_q || bus.Update);
        pend_nxt  = load ? 1'b0 : (pend_q || bus.Update);
        for (int k = 0; k < 4; k++) shadow_nxt[k] = shadow_q[k];
        if (load) begin
            shadow_nxt[0] = bus.Seven0;
            shadow_nxt[1] = bus.Seven1;
            shadow_nxt[2] = bus.Seven2;
            shadow_nxt[3] = bus.Seven3;
        end
        // DigEn is taken once per slot; the slot running out of reset
        // takes it on the first edge.
        en_nxt = (cnt_nxt == '0 || first_q) ? bus.DigEn : en_q;

        if (cnt_nxt == '0)
            state_nxt = (GAP == 0) ? SHOW : BLANK;
        else if (cnt_nxt >= CW'(GAP))
            state_nxt = SHOW;
        else
            state_nxt = BLANK;

        drive = (state_nxt == SHOW) && en_nxt[idx_nxt];
`ifdef BRIGHT_EN
        // PWM phase restarts at the first SHOW cycle of every slot
        ofs = 32'(cnt_nxt) - 32'(GAP);
        if (3'(ofs) > bus.Bright) drive = 1'b0;
`endif
        dig_nxt = drive ? 4'(~(4'b0001 << idx_nxt)) : 4'hF;
        sev_nxt = drive ? shadow_nxt[idx_nxt] : 7'h7F;
    end

    assign bus.SevOut    = sev_q;
    assign bus.Dig       = dig_q;
    assign bus.UpdAck    = ack_q;
    assign bus.FrameDone = fd_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized self-checking bench for seg_scan_ctrl (DIV=10, GAP=2).
// A cycle-indexed reference model derives slot/frame position arithmetically
// from the number of edges since reset.
module tb_seg_scan_ctrl;
    localparam int unsigned DIV = 10;
    localparam int unsigned GAP = 2;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    seg_scan_if bus ();

    seg_scan_ctrl #(.DIV(DIV), .GAP(GAP)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    // Reference model state
    int         n;
    int         c;
    int         i;
    bit         m_pend;
    logic [6:0] m_shadow [0:3];
    logic [3:0] m_en;
    bit         drv;
    logic [6:0] exp_sev;
    logic [3:0] exp_dig;
    logic       exp_ack;
    logic       exp_fd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Frame f starts at edge 4*DIV*f; slot = (n/DIV)%4; counter = n%DIV.
    always @(posedge CLK) begin
        if (RST) begin
            n = 0;
            m_pend = 0;
            for (int k = 0; k < 4; k++) m_shadow[k] = 7'h7F;
            m_en = 4'h0;
            exp_sev = 7'h7F;
            exp_dig = 4'hF;
            exp_ack = 1'b0;
            exp_fd  = 1'b0;
        end else begin
            n = n + 1;
            c = n % DIV;
            i = (n / DIV) % 4;
            exp_fd  = (n % (4 * DIV) == 0);
            exp_ack = 1'b0;
            if (exp_fd && (m_pend || bus.Update)) begin
                m_shadow[0] = bus.Seven0;
                m_shadow[1] = bus.Seven1;
                m_shadow[2] = bus.Seven2;
                m_shadow[3] = bus.Seven3;
                m_pend  = 0;
                exp_ack = 1'b1;
            end else if (bus.Update) begin
                m_pend = 1;
            end
            if (c == 0 || n == 1) m_en = bus.DigEn;
            drv = (c >= GAP) && m_en[i];
`ifdef BRIGHT_EN
            if (((c - GAP) % 8) > int'(bus.Bright)) drv = 0;
`endif
            exp_dig = drv ? 4'(~(4'b0001 << i)) : 4'hF;
            exp_sev = drv ? m_shadow[i] : 7'h7F;
        end
    end

    task automatic check_outputs(input string tag);
        check({tag, ".Dig"},       32'(bus.Dig),       32'(exp_dig));
        check({tag, ".SevOut"},    32'(bus.SevOut),    32'(exp_sev));
        check({tag, ".UpdAck"},    32'(bus.UpdAck),    32'(exp_ack));
        check({tag, ".FrameDone"}, 32'(bus.FrameDone), 32'(exp_fd));
    endtask

    // Assert reset between edges; outputs must blank without waiting for CLK.
    task automatic mid_reset();
        @(negedge CLK);
        #2 RST = 1'b1;
        #1;
        check("rst.Dig",       32'(bus.Dig),       32'hF);
        check("rst.SevOut",    32'(bus.SevOut),    32'h7F);
        check("rst.UpdAck",    32'(bus.UpdAck),    32'h0);
        check("rst.FrameDone", 32'(bus.FrameDone), 32'h0);
        bus.Update = 1'b0;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic run_random(input int cycles, input int upd_rate, input int en_rate);
        for (int k = 0; k < cycles; k++) begin
            @(negedge CLK);
            check_outputs("rand");
            if ($urandom_range(0, 3) == 0) begin
                bus.Seven0 = 7'($urandom);
                bus.Seven1 = 7'($urandom);
                bus.Seven2 = 7'($urandom);
                bus.Seven3 = 7'($urandom);
            end
            bus.Update = ($urandom_range(0, upd_rate - 1) == 0);
            if ($urandom_range(0, en_rate - 1) == 0) bus.DigEn = 4'($urandom);
            bus.Bright = 3'($urandom);
        end
    endtask

    initial begin
        bus.Seven0 = 7'h7F;
        bus.Seven1 = 7'h7F;
        bus.Seven2 = 7'h7F;
        bus.Seven3 = 7'h7F;
        bus.DigEn  = 4'hF;
        bus.Update = 1'b0;
        bus.Bright = 3'd7;

        repeat (3) @(negedge CLK);
        check("reset.Dig",    32'(bus.Dig),    32'hF);
        check("reset.SevOut", 32'(bus.SevOut), 32'h7F);
        check("reset.UpdAck", 32'(bus.UpdAck), 32'h0);
        RST = 1'b0;

        // Directed: Update pulse in cycle 5 with digit patterns 0..3
        for (int k = 1; k <= 100; k++) begin
            @(negedge CLK);
            check_outputs("dir");
            bus.Update = 1'b0;
            if (k == 4) begin
                bus.Seven0 = 7'b1000000;
                bus.Seven1 = 7'b1111001;
                bus.Seven2 = 7'b0100100;
                bus.Seven3 = 7'b0110000;
                bus.Update = 1'b1;
            end
            if (k == 44) bus.Seven0 = 7'b0010000;
        end

        // Pending update lost across a mid-slot reset
        bus.Update = 1'b1;
        @(negedge CLK);
        bus.Update = 1'b0;
        mid_reset();
        for (int k = 0; k < 90; k++) begin
            @(negedge CLK);
            check_outputs("post_rst");
        end

        run_random(1500, 30, 40);
        bus.DigEn = 4'b1010;
        run_random(300, 8, 100000);
        mid_reset();
        run_random(1200, 4, 25);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
